bcd_timer_ctrl: RTL and testbench

BCD_TIMER_CTRL -- requirements
Module: bcd_timer_ctrl

---
 rtl/bcd_timer_ctrl.sv | 154 +++++++++++++++
 tb/tb_bcd_timer_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_timer_ctrl.sv
// rtl/bcd_timer_ctrl.sv - four-digit BCD up/down timer with prescaled tick and run/pause/done control
// Optional macro AUTO_RELOAD_EN: reload the preset at the terminal count instead of stopping in DONE.
module bcd_timer_ctrl #(
  parameter int DIV = 50000,
  parameter int PW  = 20
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic        stop,
  input  logic        up,
  input  logic        load,
  input  logic [15:0] preset,
  output logic [15:0] q,
  output logic [1:0]  state,
  output logic        tick,
  output logic        done
);

  localparam logic [1:0]    IDLE  = 2'd0;
  localparam logic [1:0]    RUN   = 2'd1;
  localparam logic [1:0]    PAUSE = 2'd2;
  localparam logic [1:0]    DONE  = 2'd3;
  localparam logic [PW-1:0] PMAX  = PW'(DIV - 1);

  logic [1:0]    state_nxt;
  logic [PW-1:0] presc;
  logic          dir;
  logic          entry;
  logic [15:0]   preset_sat;
  logic          wrap;
  logic          at_term;
  logic          run_go;
  logic          term_hit;
`ifdef AUTO_RELOAD_EN
  logic [15:0]   preset_latch;
`endif

  function automatic logic [15:0] sat_bcd(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    for (int i = 0; i < 4; i++)
      if (v[i*4 +: 4] > 4'd9) r[i*4 +: 4] = 4'd9;
    return r;
  endfunction

  // One decimal step with ripple carry/borrow; callers never step past 9999/0000.
  function automatic logic [15:0] bcd_step(input logic [15:0] v, input logic inc);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (inc) begin
          if (v[i*4 +: 4] == 4'd9) r[i*4 +: 4] = 4'd0;
          else begin
            r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
            c = 1'b0;
          end
        end else begin
          if (v[i*4 +: 4] == 4'd0) r[i*4 +: 4] = 4'd9;
          else begin
            r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  assign preset_sat = sat_bcd(preset);
  assign wrap       = (presc == PMAX);
  assign at_term    = dir ? (q == 16'h9999) : (q == 16'h0000);
  assign run_go     = (state == RUN) && !stop;
  // Terminal reached either by a tick or by entering RUN already sitting on it.
  assign term_hit   = run_go && at_term && (wrap || entry);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = RUN;
      RUN: begin
        if (stop) state_nxt = PAUSE;
`ifndef AUTO_RELOAD_EN
        else if (term_hit) state_nxt = DONE;
`endif
      end
      PAUSE: begin
        if (stop)       state_nxt = IDLE;
        else if (start) state_nxt = RUN;
      end
      DONE:  if (stop || load) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tick = run_go && wrap;
`ifdef AUTO_RELOAD_EN
    done = term_hit;
`else
    done = (state == DONE);
`endif
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q     <= 16'h0000;
      presc <= '0;
      dir   <= 1'b1;
      entry <= 1'b0;
    end else begin
      entry <= (state == IDLE) && start;
      case (state)
        IDLE: begin
          if (load) q <= preset_sat;
          if (start) begin
            presc <= '0;
            dir   <= up;
          end
        end
        RUN: begin
          if (!stop) begin
            presc <= wrap ? '0 : presc + 1'b1;
            if (term_hit) begin
`ifdef AUTO_RELOAD_EN
              q <= preset_latch;
`endif
            end else if (wrap) begin
              q <= bcd_step(q, dir);
            end
          end
        end
        DONE: if (load) q <= preset_sat;
        default: ;
      endcase
    end
  end

`ifdef AUTO_RELOAD_EN
  always_ff @(posedge clk or posedge clr) begin
    if (clr) preset_latch <= 16'h0000;
    else if (load && (state == IDLE || state == DONE)) preset_latch <= preset_sat;
  end
`endif

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// tb/tb_bcd_timer_ctrl.sv - self-checking bench for bcd_timer_ctrl with DIV=4
`timescale 1ns/100ps
module tb_bcd_timer_ctrl;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        up = 1'b0;
  logic        load = 1'b0;
  logic [15:0] preset = 16'h0000;
  logic [15:0] q;
  logic [1:0]  state;
  logic        tick;
  logic        done;

  int n_checks = 0;
  int n_fail = 0;

  bcd_timer_ctrl #(.DIV(DIV), .PW(4)) dut (
    .clk(clk), .clr(clr), .start(start), .stop(stop), .up(up), .load(load),
    .preset(preset), .q(q), .state(state), .tick(tick), .done(done)
  );

  always #5 clk = ~clk;

  function automatic int sat_dec(input logic [15:0] p);
    int v;
    int d;
    v = 0;
    for (int i = 3; i >= 0; i--) begin
      d = int'(p[i*4 +: 4]);
      if (d > 9) d = 9;
      v = v * 10 + d;
    end
    return v;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[3:0]   = 4'((v)        % 10);
    r[7:4]   = 4'((v / 10)   % 10);
    r[11:8]  = 4'((v / 100)  % 10);
    r[15:12] = 4'((v / 1000) % 10);
    return r;
  endfunction

  task automatic apply(input logic s, input logic p, input logic u, input logic l, input logic [15:0] pr);
    @(negedge clk);
    start = s; stop = p; up = u; load = l; preset = pr;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    start = 0; stop = 0; up = 0; load = 0; preset = 16'h0000;
    clr = 1'b1;
    #3;
    clr = 1'b0;
  endtask

  task automatic wait_tick(output bit found);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      apply(0, 0, 0, 0, 16'h0000);
      if (tick === 1'b1) begin
        found = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    #2 clr = 1'b1;
    #1;
    n_checks++; if (q !== 16'h0000) begin n_fail++; $display("FAIL reset_q got %h want 0000", q); end
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", state); end
    n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick got %b want 0", tick); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    @(negedge clk);
    #2 clr = 1'b0;
    apply(0, 0, 0, 0, 16'h0000);
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_idle_hold got %0d want 0", state); end
  endtask

  task automatic test_countdown();
    int gap;
    int nt;
    do_reset();
    apply(0, 0, 0, 1, 16'h0003);
    apply(1, 0, 0, 0, 16'h0000);
    gap = 0;
    nt = 0;
    for (int c = 0; c < 40 && nt < 4; c++) begin
      apply(0, 0, 0, 0, 16'h0000);
      gap++;
      if (tick === 1'b1) begin
        nt++;
        n_checks++; if (gap != 4) begin n_fail++; $display("FAIL cd_period tick %0d got gap %0d want 4", nt, gap); end
        n_checks++; if (q !== to_bcd(4 - nt)) begin n_fail++; $display("FAIL cd_q tick %0d got %h want %h", nt, q, to_bcd(4 - nt)); end
        gap = 0;
      end
    end
    n_checks++; if (nt != 4) begin n_fail++; $display("FAIL cd_ticks got %0d want 4", nt); end
    apply(0, 0, 0, 0, 16'h0000);
    n_checks++; if (state !== 2'd3) begin n_fail++; $display("FAIL cd_state got %0d want 3", state); end
    n_checks++; if (q !== 16'h0000) begin n_fail++; $display("FAIL cd_hold got %h want 0000", q); end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL cd_done got %b want 1", done); end
    apply(0, 0, 0, 0, 16'h0000);
    n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL cd_done_tick got %b want 0", tick); end
  endtask

  task automatic test_ripple();
    bit f;
    do_reset();
    apply(0, 0, 1, 1, 16'h0099);
    apply(1, 0, 1, 0, 16'h0000);
    wait_tick(f);
    n_checks++; if (!f) begin n_fail++; $display("FAIL carry_tick got none want tick"); end
    apply(0, 0, 0, 0, 16'h0000);
    n_checks++; if (q !== 16'h0100) begin n_fail++; $display("FAIL carry_q got %h want 0100", q); end
    apply(0, 1, 0, 0, 16'h0000);
    apply(0, 1, 0, 0, 16'h0000);
    apply(0, 0, 0, 1, 16'h1000);
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL borrow_idle got %0d want 0", state); end
    apply(1, 0, 0, 0, 16'h0000);
    wait_tick(f);
    n_checks++; if (!f) begin n_fail++; $display("FAIL borrow_tick got none want tick"); end
    apply(0, 0, 0, 0, 16'h0000);
    n_checks++; if (q !== 16'h0999) begin n_fail++; $display("FAIL borrow_q got %h want 0999", q); end
  endtask

  task automatic test_pause();
    do_reset();
    apply(0, 0, 1, 1, 16'h0500);
    apply(1, 0, 1, 0, 16'h0000);
    apply(0, 0, 0, 0, 16'h0000);
    apply(0, 0, 0, 0, 16'h0000);
    apply(0, 1, 0, 0, 16'h0000);
    n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL pause_stop_tick got %b want 0", tick); end
    apply(0, 0, 0, 0, 16'h0000);
    n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL pause_state got %0d want 2", state); end
    apply(1, 0, 0, 0, 16'h0000);
    apply(0, 0, 0, 0, 16'h0000);
    n_checks++; if (state !== 2'd1 || tick !== 1'b0) begin n_fail++; $display("FAIL resume_first got st %0d tick %b want 1/0", state, tick); end
    apply(0, 0, 0, 0, 16'h0000);
    n_checks++; if (tick !== 1'b1) begin n_fail++; $display("FAIL resume_tick got %b want 1", tick); end
    apply(0, 0, 0, 0, 16'h0000);
    n_checks++; if (q !== 16'h0501) begin n_fail++; $display("FAIL resume_q got %h want 0501", q); end
    apply(0, 0, 0, 0, 16'h0000);
    apply(0, 0, 0, 0, 16'h0000);
    apply(0, 1, 0, 0, 16'h0000);
    n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL stop_prio_tick got %b want 0", tick); end
    apply(1, 0, 0, 0, 16'h0000);
    n_checks++; if (q !== 16'h0501) begin n_fail++; $display("FAIL stop_prio_q got %h want 0501", q); end
    apply(0, 0, 0, 0, 16'h0000);
    n_checks++; if (tick !== 1'b1) begin n_fail++; $display("FAIL retained_tick got %b want 1", tick); end
    apply(0, 0, 0, 0, 16'h0000);
    n_checks++; if (q !== 16'h0502) begin n_fail++; $display("FAIL retained_q got %h want 0502", q); end
  endtask

  task automatic test_pause_exit();
    do_reset();
    apply(0, 0, 1, 1, 16'h0200);
    apply(1, 0, 1, 0, 16'h0000);
    apply(0, 0, 1, 1, 16'h0777);
    apply(0, 0, 0, 0, 16'h0000);
    n_checks++; if (q !== 16'h0200) begin n_fail++; $display("FAIL run_load_q got %h want 0200", q); end
    apply(0, 1, 0, 0, 16'h0000);
    apply(1, 1, 0, 0, 16'h0000);
    n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL pause_both_pre got %0d want 2", state); end
    apply(0, 0, 0, 0, 16'h0000);
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL pause_both_idle got %0d want 0", state); end
    n_checks++; if (q !== 16'h0200) begin n_fail++; $display("FAIL pause_both_q got %h want 0200", q); end
  endtask

  task automatic test_sanitize_terminal();
    do_reset();
    apply(0, 0, 0, 1, 16'hA5F0);
    apply(0, 0, 0, 0, 16'h0000);
    n_checks++; if (q !== 16'h9590) begin n_fail++; $display("FAIL sat_q got %h want 9590", q); end
    apply(1, 0, 0, 1, 16'h0000);
    apply(0, 0, 0, 0, 16'h0000);
    n_checks++; if (state !== 2'd1 || tick !== 1'b0) begin n_fail++; $display("FAIL term_entry got st %0d tick %b want 1/0", state, tick); end
    apply(0, 0, 0, 0, 16'h0000);
    n_checks++; if (state !== 2'd3 || done !== 1'b1) begin n_fail++; $display("FAIL term_done got st %0d done %b want 3/1", state, done); end
    apply(1, 0, 0, 0, 16'h0000);
    apply(0, 0, 0, 1, 16'h0042);
    n_checks++; if (state !== 2'd3) begin n_fail++; $display("FAIL done_start got %0d want 3", state); end
    apply(0, 0, 0, 0, 16'h0000);
    n_checks++; if (state !== 2'd0 || q !== 16'h0042) begin n_fail++; $display("FAIL done_load got st %0d q %h want 0/0042", state, q); end
  endtask

  task automatic test_up_terminal();
    bit f;
    do_reset();
    apply(0, 0, 1, 1, 16'h9998);
    apply(1, 0, 1, 0, 16'h0000);
    wait_tick(f);
    apply(0, 0, 0, 0, 16'h0000);
    n_checks++; if (!f || q !== 16'h9999) begin n_fail++; $display("FAIL up_step got %h want 9999", q); end
    wait_tick(f);
    apply(0, 0, 0, 0, 16'h0000);
    n_checks++; if (!f || state !== 2'd3 || q !== 16'h9999) begin n_fail++; $display("FAIL up_done got st %0d q %h want 3/9999", state, q); end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    apply(0, 0, 0, 1, 16'h0300);
    apply(1, 0, 0, 0, 16'h0000);
    for (int i = 0; i < 4; i++) apply(0, 0, 0, 0, 16'h0000);
    n_checks++; if (tick !== 1'b1) begin n_fail++; $display("FAIL midrun_pending got %b want 1", tick); end
    #2 clr = 1'b1;
    #1;
    n_checks++; if (q !== 16'h0000 || state !== 2'd0) begin n_fail++; $display("FAIL midrun_async got q %h st %0d want 0000/0", q, state); end
    n_checks++; if (tick !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL midrun_strobes got %b%b want 00", tick, done); end
    @(negedge clk);
    #2 clr = 1'b0;
    apply(0, 0, 0, 1, 16'h0005);
    apply(0, 0, 0, 0, 16'h0000);
    n_checks++; if (q !== 16'h0005 || state !== 2'd0) begin n_fail++; $display("FAIL midrun_idle got q %h st %0d want 0005/0", q, state); end
  endtask

`ifdef AUTO_RELOAD_EN
  task automatic test_auto_reload();
    bit f;
    do_reset();
    apply(0, 0, 0, 1, 16'h0002);
    apply(1, 0, 0, 0, 16'h0000);
    wait_tick(f);
    apply(0, 0, 0, 0, 16'h0000);
    n_checks++; if (!f || q !== 16'h0001) begin n_fail++; $display("FAIL ar_q1 got %h want 0001", q); end
    wait_tick(f);
    apply(0, 0, 0, 0, 16'h0000);
    n_checks++; if (!f || q !== 16'h0000) begin n_fail++; $display("FAIL ar_q0 got %h want 0000", q); end
    wait_tick(f);
    n_checks++; if (!f || done !== 1'b1) begin n_fail++; $display("FAIL ar_done got %b want 1", done); end
    apply(0, 0, 0, 0, 16'h0000);
    n_checks++; if (q !== 16'h0002 || state !== 2'd1 || done !== 1'b0) begin n_fail++; $display("FAIL ar_reload got q %h st %0d done %b want 0002/1/0", q, state, done); end
  endtask
`endif

  task automatic test_random();
    int m_q, m_st, m_pre, m_latch, nq, nst;
    bit m_dir, m_new, e_tick, e_done, hit;
    logic s, p, u, l;
    logic [15:0] pr;
    do_reset();
    m_q = 0; m_st = 0; m_pre = 0; m_latch = 0; m_dir = 1'b1; m_new = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      s = ($urandom_range(0, 99) < 25);
      p = ($urandom_range(0, 99) < 8);
      u = 1'($urandom_range(0, 1));
      l = ($urandom_range(0, 99) < 12);
      case ($urandom_range(0, 5))
        0: pr = 16'h0000;
        1: pr = 16'h9999;
        2: pr = 16'h0002;
        3: pr = 16'h9997;
        4: pr = 16'($urandom);
        default: pr = to_bcd(int'($urandom_range(0, 30)));
      endcase
      apply(s, p, u, l, pr);
      e_tick = (m_st == 1) && !p && (m_pre == DIV - 1);
      hit = (m_st == 1) && !p && (m_q == (m_dir ? 9999 : 0)) && (e_tick || m_new);
`ifdef AUTO_RELOAD_EN
      e_done = hit;
`else
      e_done = (m_st == 3);
`endif
      n_checks++; if (q !== to_bcd(m_q)) begin n_fail++; $display("FAIL rand_q cyc %0d got %h want %h", c, q, to_bcd(m_q)); end
      n_checks++; if (state !== 2'(m_st)) begin n_fail++; $display("FAIL rand_state cyc %0d got %0d want %0d", c, state, m_st); end
      n_checks++; if (tick !== e_tick) begin n_fail++; $display("FAIL rand_tick cyc %0d got %b want %b", c, tick, e_tick); end
      n_checks++; if (done !== e_done) begin n_fail++; $display("FAIL rand_done cyc %0d got %b want %b", c, done, e_done); end
      nq = m_q; nst = m_st;
      case (m_st)
        0: begin
          if (l) begin nq = sat_dec(pr); m_latch = nq; end
          if (s) begin nst = 1; m_pre = 0; m_dir = u; end
        end
        1: begin
          if (p) nst = 2;
          else begin
            if (hit) begin
`ifdef AUTO_RELOAD_EN
              nq = m_latch;
`else
              nst = 3;
`endif
            end else if (e_tick) nq = m_dir ? m_q + 1 : m_q - 1;
            m_pre = (m_pre + 1) % DIV;
          end
        end
        2: begin
          if (p) nst = 0;
          else if (s) nst = 1;
        end
        default: begin
          if (p || l) nst = 0;
          if (l) begin nq = sat_dec(pr); m_latch = nq; end
        end
      endcase
      m_new = (m_st == 0) && s;
      m_q = nq;
      m_st = nst;
    end
  endtask

  initial begin
    test_reset();
`ifndef AUTO_RELOAD_EN
    test_countdown();
    test_ripple();
    test_pause();
    test_pause_exit();
    test_sanitize_terminal();
    test_up_terminal();
`else
    test_auto_reload();
`endif
    test_reset_midrun();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
